// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded MIPS register file.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    localparam logic [DATA_W_DEF-1:0] DATA_RST = '0;

    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-producer bits per register plus an exact popcount of those bits.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic                          iss_en,
    input  logic [ADDR_W-1:0]             iss_addr,
    input  logic                          flush,
    output logic [depth_of(ADDR_W)-1:0]   pend,
    output logic [ADDR_W:0]               pend_cnt
);

    localparam int unsigned DEPTH = depth_of(ADDR_W);
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic              wr_ok;
    logic              iss_ok;
    logic              inc;
    logic              dec;
    logic [DEPTH-1:0]  pend_nxt;
    logic [CNT_W-1:0]  cnt_nxt;

    // Flush beats issue, issue beats a same-address writeback; the counter moves by the bit changes.
    always_comb begin
        wr_ok    = wr_en  && !(ZERO_R0 && (wr_addr  == '0));
        iss_ok   = iss_en && !(ZERO_R0 && (iss_addr == '0));
        inc      = iss_ok && !pend[iss_addr];
        dec      = wr_ok && pend[wr_addr] && !(iss_ok && (iss_addr == wr_addr));
        pend_nxt = pend;
        cnt_nxt  = pend_cnt;
        if (flush) begin
            pend_nxt = '0;
            cnt_nxt  = '0;
        end else begin
            if (wr_ok) begin
                pend_nxt[wr_addr] = 1'b0;
            end
            if (iss_ok) begin
                pend_nxt[iss_addr] = 1'b1;
            end
            cnt_nxt = pend_cnt + CNT_W'(inc) - CNT_W'(dec);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend     <= pend_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two async read ports, one write port, optional bypass
// and a pending-write scoreboard feeding per-port busy flags.
module reg_file_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter bit          ZERO_R0 = 1'b1,
    parameter bit          BYPASS  = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  A1,
    input  logic [ADDR_W-1:0]  A2,
    output logic [DATA_W-1:0]  RD1,
    output logic [DATA_W-1:0]  RD2,
    output logic               BUSY1,
    output logic               BUSY2,
    input  logic               WE,
    input  logic [ADDR_W-1:0]  A3,
    input  logic [DATA_W-1:0]  WD3,
    input  logic               ISS_EN,
    input  logic [ADDR_W-1:0]  ISS_A,
    input  logic               FLUSH,
    output logic [ADDR_W:0]    PEND_CNT
);

    localparam int unsigned DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic              wr_ok;
    logic              byp_ok;

    always_comb begin
        wr_ok  = WE && !(ZERO_R0 && (A3 == '0));
        byp_ok = BYPASS && rst_n && wr_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= DATA_W'(DATA_RST);
            end
        end else if (wr_ok) begin
            regs[A3] <= WD3;
        end
    end

    // Read muxes: r0 forcing has the last word over any forwarded write.
    always_comb begin
        RD1   = regs[A1];
        BUSY1 = pend[A1];
        if (byp_ok && (A3 == A1)) begin
            RD1   = WD3;
            BUSY1 = 1'b0;
        end
        if (ZERO_R0 && (A1 == '0)) begin
            RD1   = '0;
            BUSY1 = 1'b0;
        end
    end

    always_comb begin
        RD2   = regs[A2];
        BUSY2 = pend[A2];
        if (byp_ok && (A3 == A2)) begin
            RD2   = WD3;
            BUSY2 = 1'b0;
        end
        if (ZERO_R0 && (A2 == '0)) begin
            RD2   = '0;
            BUSY2 = 1'b0;
        end
    end

    reg_scoreboard #(
        .ADDR_W  (ADDR_W),
        .ZERO_R0 (ZERO_R0)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (WE),
        .wr_addr  (A3),
        .iss_en   (ISS_EN),
        .iss_addr (ISS_A),
        .flush    (FLUSH),
        .pend     (pend),
        .pend_cnt (PEND_CNT)
    );

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with a per-register pending-write scoreboard, for the next-generation pipelined MIPS core. Provides two asynchronous read ports, one write port and an optional write-to-read bypass. Tracks which registers have an in-flight producer: decode marks a destination at issue, writeback clears it. Exports per-port busy flags and a pending count so the hazard unit can stall without its own tracking state.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- ZERO_R0, 1, 1 = register 0 hardwired to zero, never written, never pending
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- A1, A2  in  ADDR_W  read addresses
- RD1, RD2  out  DATA_W  read data (combinational)
- BUSY1, BUSY2  out  1  addressed register has an outstanding producer
- WE  in  1  write enable
- A3  in  ADDR_W  write address
- WD3  in  DATA_W  write data
- ISS_EN  in  1  mark register ISS_A pending
- ISS_A  in  ADDR_W  issued destination address
- FLUSH  in  1  clear all pending bits (pipeline squash)
- PEND_CNT  out  ADDR_W+1  number of pending registers

## Operation
- Reset (rst_n low, asynchronous):
  - all registers 0, all pending bits 0, PEND_CNT = 0.
  - Hence RD1/RD2 = 0 and BUSY1/BUSY2 = 0 while in reset.
- Write: on a clk edge with WE=1, regs[A3] <= WD3 and pend[A3] <= 0. If ZERO_R0=1 and A3=0, the write is dropped.
- Read: RDn = regs[An].
  - If BYPASS=1, WE=1, A3=An and the write is not dropped, RDn = WD3 in the same cycle.
  - If ZERO_R0=1 and An=0, RDn = 0 always.
- Busy: BUSYn = pend[An], forced 0 when BYPASS=1 and a non-dropped write to An occurs this cycle. If ZERO_R0=1, BUSYn = 0 when An = 0.
- Issue: on a clk edge with ISS_EN=1, pend[ISS_A] <= 1. Ignored for ISS_A=0 when ZERO_R0=1. Issue to an already-pending register keeps it pending.
- Simultaneous write and issue, same address: issue wins. Data is written, pend stays/becomes 1, PEND_CNT net change is +1 if the bit was clear, else 0.
- FLUSH=1 on an edge: all pend bits 0 and PEND_CNT 0. FLUSH beats a same-cycle issue. A same-cycle write still updates data.
- PEND_CNT tracks the popcount of pend[] exactly:
  - +1 when an issue sets a clear bit.
  - -1 when a write clears a set bit (different address from any same-cycle issue).
  - Both in one cycle: net 0.
  - Never wraps; maximum is DEPTH (or DEPTH-1 with ZERO_R0).
- A write to a non-pending register changes data only; PEND_CNT is unchanged.

## Timing
- Read latency: 0 cycles (combinational on An, regs, and WD3 when bypassed).
- Write visibility: same cycle with BYPASS=1; cycle after the edge with BYPASS=0.
- Issue to BUSY: BUSY asserts the cycle after the issuing edge.
- Writeback to BUSY: BUSY deasserts in the write cycle with BYPASS=1; the next cycle with BYPASS=0.
- PEND_CNT: registered, updates one edge after the event.
- Reset asserted mid-operation: state clears immediately, without waiting for clk. Released state is all-zero; the first edge after release behaves normally.

## Structure
- Package regfile_pkg holds:
  - default DATA_W/ADDR_W constants;
  - a localparam function for DEPTH;
  - the reset value of the data words (0).
- Sub-module reg_scoreboard holds pend[] and PEND_CNT: the issue/write/flush priority logic and the counter, with parameters ADDR_W and ZERO_R0.
- The top level holds the data array, read muxes, bypass and BUSY gating.

## Test plan
- Reset, then read all 32 addresses -> RD = 0x00000000, BUSY = 0, PEND_CNT = 0.
- WE=1, A3=5, WD3=0xDEADBEEF, A1=5 in the same cycle -> RD1 = 0xDEADBEEF that cycle (BYPASS=1), and in the next cycle (BYPASS=0 build).
- ISS_A=7 issued, two idle cycles, then write A3=7, WD3=0x12345678 -> BUSY1 (A1=7) = 1 for two cycles, 0 in the write cycle; PEND_CNT goes 0→1→0.
- Write to r0 with 0xFFFFFFFF and ISS_A=0 -> RD1 (A1=0) = 0, BUSY1 = 0, PEND_CNT = 0.
- Issue and write to r9 in the same cycle, then issue r3 with FLUSH=1 -> r9 data updated and pending, PEND_CNT = 1; after the flush edge, PEND_CNT = 0 and r3 is not pending.
- Issue r1..r31 on consecutive cycles, then drop rst_n between clock edges -> PEND_CNT reads 31, then 0 immediately on reset, and all registers read 0.
